matrix_mult_sequencer: RTL and testbench

//  Front-end controller for the 3-term dot-product datapath (row*col sum, W-bit, registered result).

---
 rtl/matrix_mult_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_matrix_mult_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer
// Front-end controller for an external 3-term dot-product datapath.
// Stores two 3x3 operand matrices (A, B), walks the nine C[i][j] results
// in row-major order by presenting row i of A and column j of B to the
// datapath, captures each result and hands it out on a valid/ready port.
// All outputs are registered; the next-cycle values are decoded from the
// next-state logic so the ports line up with the state they belong to.

module matrix_mult_sequencer #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic         ld_sel,
  input  logic [3:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dp_row_a,
  output logic [W-1:0] dp_row_b,
  output logic [W-1:0] dp_row_c,
  output logic [W-1:0] dp_col_a,
  output logic [W-1:0] dp_col_b,
  output logic [W-1:0] dp_col_c,
  input  logic [W-1:0] dp_result,
  output logic         c_valid,
  input  logic         c_ready,
  output logic [3:0]   c_idx,
  output logic [W-1:0] c_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // ISSUE lasts LAT cycles; the counter runs 0 .. LAT-1
  localparam logic [1:0] LAT_M1 = 2'(LAT - 1);
  localparam logic [3:0] K_LAST = 4'd8;
  localparam logic [3:0] N_ELEM = 4'd9;

  // first element index of row i for a row-major index k
  function automatic logic [3:0] row_base(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: row_base = 4'd0;
      4'd3, 4'd4, 4'd5: row_base = 4'd3;
      4'd6, 4'd7, 4'd8: row_base = 4'd6;
      default:          row_base = 4'd0;
    endcase
  endfunction

  // column j for a row-major index k
  function automatic logic [3:0] col_of(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: col_of = 4'd0;
      4'd1, 4'd4, 4'd7: col_of = 4'd1;
      4'd2, 4'd5, 4'd8: col_of = 4'd2;
      default:          col_of = 4'd0;
    endcase
  endfunction

  // registered state
  state_t       state_r;
  logic [3:0]   k_r;
  logic [1:0]   lat_cnt_r;
  logic [W-1:0] a_r [0:8];
  logic [W-1:0] b_r [0:8];

  // registered outputs
  logic         ld_ready_r;
  logic         busy_r;
  logic         done_r;
  logic         c_valid_r;
  logic [3:0]   c_idx_r;
  logic [W-1:0] c_data_r;
  logic [W-1:0] dp_row_a_r, dp_row_b_r, dp_row_c_r;
  logic [W-1:0] dp_col_a_r, dp_col_b_r, dp_col_c_r;

  // next-state / combinational signals
  state_t       state_s;
  logic [3:0]   k_s;
  logic [1:0]   lat_cnt_s;
  logic         capture_s;
  logic [W-1:0] a_s [0:8];
  logic [W-1:0] b_s [0:8];
  logic         dp_en_s;
  logic [3:0]   rb_s;
  logic [3:0]   cj_s;
  logic [W-1:0] dp_row_a_s, dp_row_b_s, dp_row_c_s;
  logic [W-1:0] dp_col_a_s, dp_col_b_s, dp_col_c_s;

  // sequencer next state, element index and ISSUE dwell counter
  always_comb begin
    state_s   = state_r;
    k_s       = k_r;
    lat_cnt_s = lat_cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_ISSUE;
          k_s       = 4'd0;
          lat_cnt_s = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (lat_cnt_r == LAT_M1) begin
          state_s   = ST_CAPT;
          lat_cnt_s = 2'd0;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      ST_CAPT: begin
        state_s   = ST_OUT;
        capture_s = 1'b1;
      end
      ST_OUT: begin
        if (c_ready) begin
          if (k_r == K_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s   = ST_ISSUE;
            k_s       = k_r + 4'd1;
            lat_cnt_s = 2'd0;
          end
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        k_s       = 4'd0;
        lat_cnt_s = 2'd0;
      end
    endcase
  end

  // operand storage write port; only open while idle, indices 9..15 fall through
  always_comb begin
    for (int n = 0; n < 9; n++) begin
      a_s[n] = a_r[n];
      b_s[n] = b_r[n];
    end
    if (ld_valid && ld_ready_r && (ld_addr < N_ELEM)) begin
      if (ld_sel) begin
        b_s[ld_addr] = ld_data;
      end else begin
        a_s[ld_addr] = ld_data;
      end
    end else begin
      a_s[0] = a_r[0];
    end
  end

  // operand bus for the next cycle; uses post-write storage so a load on the
  // start edge is already visible in the first ISSUE cycle
  always_comb begin
    dp_en_s = (state_s == ST_ISSUE) || (state_s == ST_CAPT);
    rb_s    = row_base(k_s);
    cj_s    = col_of(k_s);
    if (dp_en_s) begin
      dp_row_a_s = a_s[rb_s];
      dp_row_b_s = a_s[rb_s + 4'd1];
      dp_row_c_s = a_s[rb_s + 4'd2];
      dp_col_a_s = b_s[cj_s];
      dp_col_b_s = b_s[cj_s + 4'd3];
      dp_col_c_s = b_s[cj_s + 4'd6];
    end else begin
      dp_row_a_s = {W{1'b0}};
      dp_row_b_s = {W{1'b0}};
      dp_row_c_s = {W{1'b0}};
      dp_col_a_s = {W{1'b0}};
      dp_col_b_s = {W{1'b0}};
      dp_col_c_s = {W{1'b0}};
    end
  end

  // state, storage and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      k_r        <= 4'd0;
      lat_cnt_r  <= 2'd0;
      for (int n = 0; n < 9; n++) begin
        a_r[n] <= {W{1'b0}};
        b_r[n] <= {W{1'b0}};
      end
      ld_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      c_valid_r  <= 1'b0;
      c_idx_r    <= 4'd0;
      c_data_r   <= {W{1'b0}};
      dp_row_a_r <= {W{1'b0}};
      dp_row_b_r <= {W{1'b0}};
      dp_row_c_r <= {W{1'b0}};
      dp_col_a_r <= {W{1'b0}};
      dp_col_b_r <= {W{1'b0}};
      dp_col_c_r <= {W{1'b0}};
    end else begin
      state_r    <= state_s;
      k_r        <= k_s;
      lat_cnt_r  <= lat_cnt_s;
      for (int n = 0; n < 9; n++) begin
        a_r[n] <= a_s[n];
        b_r[n] <= b_s[n];
      end
      ld_ready_r <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      c_valid_r  <= (state_s == ST_OUT);
      if (capture_s) begin
        c_data_r <= dp_result;
        c_idx_r  <= k_r;
      end
      dp_row_a_r <= dp_row_a_s;
      dp_row_b_r <= dp_row_b_s;
      dp_row_c_r <= dp_row_c_s;
      dp_col_a_r <= dp_col_a_s;
      dp_col_b_r <= dp_col_b_s;
      dp_col_c_r <= dp_col_c_s;
    end
  end

  assign ld_ready = ld_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign c_valid  = c_valid_r;
  assign c_idx    = c_idx_r;
  assign c_data   = c_data_r;
  assign dp_row_a = dp_row_a_r;
  assign dp_row_b = dp_row_b_r;
  assign dp_row_c = dp_row_c_r;
  assign dp_col_a = dp_col_a_r;
  assign dp_col_b = dp_col_b_r;
  assign dp_col_c = dp_col_c_r;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Self-checking bench for matrix_mult_sequencer.
// A behavioural datapath (registered 3-term dot product) closes the loop;
// expected C values come from a plain matrix-multiply reference model.

module tb_matrix_mult_sequencer;

  localparam int W   = 16;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld_valid = 1'b0;
  logic         ld_sel = 1'b0;
  logic [3:0]   ld_addr = 4'd0;
  logic [W-1:0] ld_data = 16'h0000;
  logic         start = 1'b0;
  logic         c_ready = 1'b0;
  logic         ld_ready, busy, done, c_valid;
  logic [3:0]   c_idx;
  logic [W-1:0] c_data, dp_result;
  logic [W-1:0] dp_row_a, dp_row_b, dp_row_c, dp_col_a, dp_col_b, dp_col_c;

  always #5 clk = ~clk;

  matrix_mult_sequencer #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done),
    .dp_row_a(dp_row_a), .dp_row_b(dp_row_b), .dp_row_c(dp_row_c),
    .dp_col_a(dp_col_a), .dp_col_b(dp_col_b), .dp_col_c(dp_col_c),
    .dp_result(dp_result),
    .c_valid(c_valid), .c_ready(c_ready), .c_idx(c_idx), .c_data(c_data)
  );

  // behavioural datapath: LAT-stage registered dot product, wraps at W bits
  logic [W-1:0] dp_pipe [0:LAT-1];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_row_a * dp_col_a + dp_row_b * dp_col_b + dp_row_c * dp_col_c;
    for (int s = 1; s < LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign dp_result = dp_pipe[LAT-1];

  int n_err = 0;
  int n_chk = 0;
  logic [W-1:0] ma [0:8];
  logic [W-1:0] mb [0:8];
  logic [W-1:0] got [0:8];

  typedef struct {
    int           a_mode;   // 0 diagonal(val), 1 uniform(val), 2 ramp(val+n)
    logic [W-1:0] a_val;
    int           b_mode;
    logic [W-1:0] b_val;
    logic [W-1:0] exp_c0;
    logic [W-1:0] exp_c8;
  } vec_t;
  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: C[i][j] = sum_t A[i][t]*B[t][j] mod 2^W
  function automatic logic [W-1:0] ref_c(input int k);
    int unsigned s;
    int i, j;
    i = k / 3;
    j = k % 3;
    s = 0;
    for (int t = 0; t < 3; t++) s = s + ma[3*i+t] * mb[3*t+j];
    return s[W-1:0];
  endfunction

  // one write on the next edge; caller is at a negedge
  task automatic load(input logic sel, input logic [3:0] addr, input logic [W-1:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_model(input logic sel, input logic [3:0] addr, input logic [W-1:0] data);
    load(sel, addr, data);
    if (addr < 4'd9) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  task automatic fill(input logic sel, input int mode, input logic [W-1:0] val);
    logic [W-1:0] v;
    for (int n = 0; n < 9; n++) begin
      case (mode)
        0:       v = (n == 0 || n == 4 || n == 8) ? val : 16'h0000;
        1:       v = val;
        default: v = val + 16'(n);
      endcase
      load_model(sel, 4'(n), v);
    end
  endtask

  // mode 0: c_ready=1; 1: stall 5 cycles at k=4; 2: random c_ready;
  // 3: c_ready=1 with ld_valid pulsed while busy (must be dropped)
  task automatic run(input int mode, input logic wl, input logic wsel,
                     input logic [3:0] waddr, input logic [W-1:0] wdata);
    int cyc, nacc, stall;
    logic [W-1:0] exp_q [0:8];
    start = 1'b1;
    if (wl) begin
      ld_valid = 1'b1; ld_sel = wsel; ld_addr = waddr; ld_data = wdata;
      if (waddr < 4'd9) begin
        if (wsel) mb[waddr] = wdata;
        else      ma[waddr] = wdata;
      end
    end
    for (int k = 0; k < 9; k++) exp_q[k] = ref_c(k);
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    cyc = 1; nacc = 0; stall = 0;
    chk("busy_after_start", busy, 1);
    chk("ld_ready_busy", ld_ready, 0);
    chk("dp_row_a_k0", dp_row_a, ma[0]);
    chk("dp_row_b_k0", dp_row_b, ma[1]);
    chk("dp_row_c_k0", dp_row_c, ma[2]);
    chk("dp_col_a_k0", dp_col_a, mb[0]);
    chk("dp_col_b_k0", dp_col_b, mb[3]);
    chk("dp_col_c_k0", dp_col_c, mb[6]);
    while (cyc < 2000) begin
      if (done) break;
      case (mode)
        1: begin
          if (c_valid && c_idx == 4'd4 && stall < 5) begin
            c_ready = 1'b0;
            chk("stall_data", c_data, exp_q[4]);
            chk("stall_busy", busy, 1);
            stall++;
          end else begin
            c_ready = 1'b1;
          end
        end
        2: c_ready = 1'($urandom_range(0, 1));
        3: begin
          c_ready = 1'b1;
          chk("ld_ready_low_busy", ld_ready, 0);
          ld_valid = 1'b1; ld_sel = 1'($urandom_range(0, 1));
          ld_addr = 4'($urandom_range(0, 8)); ld_data = 16'($urandom);
        end
        default: c_ready = 1'b1;
      endcase
      if (c_valid) begin
        chk("dp_zero_in_out", {dp_row_a | dp_row_b | dp_row_c | dp_col_a | dp_col_b | dp_col_c}, 0);
      end
      if (c_valid && c_ready) begin
        if (nacc < 9) begin
          chk($sformatf("c_idx_%0d", nacc), c_idx, nacc);
          chk($sformatf("c_data_%0d", nacc), c_data, exp_q[nacc]);
          got[nacc] = c_data;
        end
        nacc++;
      end
      @(negedge clk);
      cyc++;
    end
    ld_valid = 1'b0;
    chk("done_seen", done, 1);
    chk("accepted_count", nacc, 9);
    if (mode == 0) chk("start_to_done_cycles", cyc + 1, 29);
    if (mode == 1) chk("stall_cycles", stall, 5);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("ld_ready_after_done", ld_ready, 1);
    chk("c_valid_after_done", c_valid, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 16'h0001, 2, 16'h0001, 16'h0001, 16'h0009}; // T1 identity
    vecs[1] = '{1, 16'h0002, 1, 16'h0003, 16'h0012, 16'h0012}; // T2 uniform
    vecs[2] = '{1, 16'h0100, 1, 16'h0100, 16'h0000, 16'h0000}; // T3 wrap
    vecs[3] = '{2, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0009}; // A*I = A
    vecs[4] = '{2, 16'h0001, 2, 16'h0001, 16'd30,   16'd150};  // ramp*ramp
    vecs[5] = '{1, 16'hFFFF, 1, 16'hFFFF, 16'h0003, 16'h0003}; // wrap of (-1)^2
    for (int k = 0; k < 9; k++) begin ma[k] = 16'h0000; mb[k] = 16'h0000; end

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_idx", c_idx, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_dp", {dp_row_a | dp_row_b | dp_row_c | dp_col_a | dp_col_b | dp_col_c}, 0);
    rst = 1'b1;
    @(negedge clk);

    // storage cleared by reset: nine zeros
    run(0, 1'b0, 1'b0, 4'd0, 16'h0000);

    // table-driven vectors
    for (int v = 0; v < 6; v++) begin
      fill(1'b0, vecs[v].a_mode, vecs[v].a_val);
      fill(1'b1, vecs[v].b_mode, vecs[v].b_val);
      run(0, 1'b0, 1'b0, 4'd0, 16'h0000);
      chk($sformatf("vec%0d_c0", v), got[0], vecs[v].exp_c0);
      chk($sformatf("vec%0d_c8", v), got[8], vecs[v].exp_c8);
    end

    // T4 backpressure at k=4
    fill(1'b0, 2, 16'h0001);
    fill(1'b1, 2, 16'h0001);
    run(1, 1'b0, 1'b0, 4'd0, 16'h0000);

    // write on the same edge as start is seen by the first ISSUE
    run(0, 1'b1, 1'b0, 4'd0, 16'h0042);
    chk("same_edge_write_c0", got[0], 16'h0042 * 16'd1 + 16'd2 * 16'd4 + 16'd3 * 16'd7);

    // T6 load gating: writes while busy and to index 12/9/15 are dropped
    fill(1'b0, 0, 16'h0001);
    fill(1'b1, 2, 16'h0001);
    run(3, 1'b0, 1'b0, 4'd0, 16'h0000);
    load(1'b0, 4'd12, 16'h5555);
    load(1'b1, 4'd9, 16'h5555);
    load(1'b0, 4'd15, 16'h5555);
    run(0, 1'b0, 1'b0, 4'd0, 16'h0000);
    for (int k = 0; k < 9; k++) chk($sformatf("gated_c%0d", k), got[k], 16'(k + 1));

    // T5 reset while c_idx = 5
    fill(1'b0, 2, 16'h0001);
    fill(1'b1, 2, 16'h0001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(c_valid && c_idx == 4'd5) && n < 200) begin
      c_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("reach_idx5", {c_valid, c_idx}, {1'b1, 4'd5});
    rst = 1'b0; c_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_c_valid", c_valid, 0);
    chk("midrst_c_data", c_data, 0);
    chk("midrst_dp", {dp_row_a | dp_row_b | dp_row_c | dp_col_a | dp_col_b | dp_col_c}, 0);
    for (int k = 0; k < 9; k++) begin ma[k] = 16'h0000; mb[k] = 16'h0000; end
    run(0, 1'b0, 1'b0, 4'd0, 16'h0000);

    // randomized matrices, random backpressure, stray out-of-range writes
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 9; k++) begin
        load_model(1'b0, 4'(k), 16'($urandom));
        load_model(1'b1, 4'(k), 16'($urandom));
      end
      load(1'($urandom_range(0, 1)), 4'($urandom_range(9, 15)), 16'($urandom));
      run(2, 1'b0, 1'b0, 4'd0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
